// File: rtl/fr_pkg.sv
// fr_pkg: shared command codes, field widths and FSM state encoding for the file-register command master.
package fr_pkg;
    localparam int FR_NB_CMD  = 8;
    localparam int FR_NB_DATA = 24;
    localparam int FR_NB_INST = 32;
    localparam int FR_NB_BER  = 64;

    typedef enum logic [FR_NB_CMD-1:0] {
        CMD_RESET       = 8'h00,
        CMD_EN_TX       = 8'h02,
        CMD_EN_RX       = 8'h03,
        CMD_PH_SEL      = 8'h04,
        CMD_RUN_MEM     = 8'h05,
        CMD_RD_MEM      = 8'h06,
        CMD_BER_S_I     = 8'h07,
        CMD_BER_S_Q     = 8'h08,
        CMD_BER_E_I     = 8'h09,
        CMD_BER_E_Q     = 8'h0A,
        CMD_IS_MEM_FULL = 8'h0B,
        CMD_BER_HIGH    = 8'h0C
    } fr_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SETUP_HI,
        ST_STROBE_HI,
        ST_HOLD_HI
    } fr_state_e;
endpackage

// File: rtl/fr_phase_timer.sv
// fr_phase_timer: down-counter that times one strobe phase of P_CYC cycles.
//   i_clk/i_rst_n : clock, asynchronous active-low reset
//   i_load        : reload with P_CYC-1 (start of a phase)
//   i_en          : count while a phase is running
//   o_done        : terminal pulse on the last cycle of the phase
module fr_phase_timer #(
    parameter int P_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);
    localparam int NB_CNT = (P_CYC > 1) ? $clog2(P_CYC) : 1;

    logic [NB_CNT-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= NB_CNT'(P_CYC - 1);
        else if (i_en && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = i_en && (r_cnt == '0);
endmodule

// File: rtl/fr_cmd_master.sv
// fr_cmd_master: issues setup/strobe/hold instruction words to a file register and returns its response.
//   i_clk/i_rst_n            : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  : request handshake (ready only while idle)
//   i_req_cmd/i_req_data     : command code and payload
//   i_req_wide               : 64-bit read, followed by a BER_HIGH sequence
//   o_cmd_to_fr              : instruction word {cmd, enable, payload}
//   i_data_from_fr           : data word returned by the file register
//   o_rsp_valid/o_rsp_data   : one-cycle response strobe and held response data
//   o_busy                   : sequence in progress
module fr_cmd_master
    import fr_pkg::*;
#(
    parameter int NB_C0M  = FR_NB_CMD,
    parameter int NB_DATA = FR_NB_DATA,
    parameter int NB_INST = FR_NB_INST,
    parameter int NB_BER  = FR_NB_BER,
    parameter int P_CYC   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [NB_C0M-1:0]  i_req_cmd,
    input  logic [NB_DATA-2:0] i_req_data,
    input  logic               i_req_wide,
    output logic [NB_INST-1:0] o_cmd_to_fr,
    input  logic [NB_INST-1:0] i_data_from_fr,
    output logic               o_rsp_valid,
    output logic [NB_BER-1:0]  o_rsp_data,
    output logic               o_busy
);
    fr_state_e          r_state, w_next;
    logic [NB_C0M-1:0]  r_cmd;
    logic [NB_DATA-2:0] r_data;
    logic               r_wide;
    logic [NB_INST-1:0] r_low;
    logic               r_rsp_valid;
    logic [NB_BER-1:0]  r_rsp_data;
    logic               w_accept, w_done, w_idle, w_strobe;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && i_req_valid;
    assign w_strobe = (r_state == ST_STROBE) || (r_state == ST_STROBE_HI);

    // Reloaded on acceptance and at the end of every phase, so each phase lasts exactly P_CYC cycles.
    fr_phase_timer #(.P_CYC(P_CYC)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_accept || w_done),
        .i_en    (!w_idle),
        .o_done  (w_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = i_req_valid ? ST_SETUP : ST_IDLE;
            ST_SETUP:     w_next = w_done ? ST_STROBE : ST_SETUP;
            ST_STROBE:    w_next = w_done ? ST_HOLD : ST_STROBE;
            ST_HOLD:      w_next = w_done ? (r_wide ? ST_SETUP_HI : ST_IDLE) : ST_HOLD;
            ST_SETUP_HI:  w_next = w_done ? ST_STROBE_HI : ST_SETUP_HI;
            ST_STROBE_HI: w_next = w_done ? ST_HOLD_HI : ST_STROBE_HI;
            ST_HOLD_HI:   w_next = w_done ? ST_IDLE : ST_HOLD_HI;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd       <= '0;
            r_data      <= '0;
            r_wide      <= 1'b0;
            r_low       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            // The response strobe lands on the first idle cycle after the final hold phase.
            r_rsp_valid <= w_done && ((r_state == ST_HOLD && !r_wide) || r_state == ST_HOLD_HI);
            if (w_accept) begin
                r_cmd  <= i_req_cmd;
                r_data <= i_req_data;
                r_wide <= i_req_wide;
            end
            if (w_done && r_state == ST_HOLD) begin
                r_low <= i_data_from_fr;
                if (r_wide) begin
                    r_cmd  <= NB_C0M'(CMD_BER_HIGH);
                    r_data <= '0;
                end else begin
                    r_rsp_data <= NB_BER'(i_data_from_fr);
                end
            end
            if (w_done && r_state == ST_HOLD_HI)
                r_rsp_data <= NB_BER'({i_data_from_fr, r_low});
        end
    end

    // Enable is decoded from state, so an asynchronous reset drops it immediately.
    assign o_cmd_to_fr = {r_cmd, w_strobe, r_data};
    assign o_req_ready = w_idle;
    assign o_busy      = !w_idle;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_fr_cmd_master.sv
// tb_fr_cmd_master: directed table-driven checks plus back-to-back and mid-strobe reset sequences.
module tb_fr_cmd_master;
    localparam int P = 2;

    typedef struct {
        logic [7:0]  cmd;
        logic [22:0] data;
        logic        wide;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] strobe;
        logic [63:0] rsp;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [7:0]  i_req_cmd = '0;
    logic [22:0] i_req_data = '0;
    logic        i_req_wide = 1'b0;
    logic [31:0] o_cmd_to_fr;
    logic [31:0] i_data_from_fr = '0;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_data;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    vec_t tbl[5];

    fr_cmd_master #(.P_CYC(P)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_cmd      (i_req_cmd),
        .i_req_data     (i_req_data),
        .i_req_wide     (i_req_wide),
        .o_cmd_to_fr    (o_cmd_to_fr),
        .i_data_from_fr (i_data_from_fr),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Entered and left one time unit after a rising edge with the DUT idle.
    task automatic run_vec(input vec_t v);
        int n;
        int ph;
        logic [31:0] exp;
        logic [63:0] held;
        n = v.wide ? 6 * P : 3 * P;
        i_req_valid = 1'b1;
        i_req_cmd = v.cmd;
        i_req_data = v.data;
        i_req_wide = v.wide;
        i_data_from_fr = v.lo;
        step();
        i_req_valid = 1'b0;
        for (int c = 1; c <= n; c++) begin
            ph = (c - 1) / P;
            exp = {(ph < 3) ? v.cmd : 8'h0C, (ph % 3) == 1, (ph < 3) ? v.data : 23'h0};
            chk("word", o_cmd_to_fr, exp);
            if (ph == 1) chk("strobe_word", o_cmd_to_fr, v.strobe);
            if (ph == 4) chk("strobe_hi_word", o_cmd_to_fr, 32'h0C800000);
            chk("busy", o_busy, 1);
            chk("no_early_rsp", o_rsp_valid, 0);
            i_data_from_fr = (c <= 3 * P) ? v.lo : v.hi;
            step();
        end
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_data", o_rsp_data, v.rsp);
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_req_ready, 1);
        chk("idle_enable", o_cmd_to_fr[23], 0);
        held = o_rsp_data;
        step();
        chk("rsp_pulse", o_rsp_valid, 0);
        chk("rsp_hold", o_rsp_data, held);
    endtask

    initial begin
        int seen;
        tbl[0] = '{8'h02, 23'h000001, 1'b0, 32'h12345678, 32'h0, 32'h02800001, 64'h0000000012345678};
        tbl[1] = '{8'h09, 23'h000000, 1'b1, 32'h00000003, 32'hFFFFFFFF, 32'h09800000, 64'hFFFFFFFF00000003};
        tbl[2] = '{8'h06, 23'd250, 1'b0, 32'd651, 32'h0, 32'h068000FA, 64'd651};
        tbl[3] = '{8'hFF, 23'h7FFFFF, 1'b0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 64'h00000000DEADBEEF};
        tbl[4] = '{8'h00, 23'h400000, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00C00000, 64'h5A5A5A5AA5A5A5A5};

        #12;
        chk("rst_word", o_cmd_to_fr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("rel_word", o_cmd_to_fr, 32'h00000000);
        chk("rel_ready", o_req_ready, 1);
        chk("rel_rsp_valid", o_rsp_valid, 0);
        chk("rel_rsp_data", o_rsp_data, 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back: request B waits with valid high and is taken on A's response cycle.
        i_req_valid = 1'b1;
        i_req_cmd = 8'h02;
        i_req_data = 23'd5;
        i_req_wide = 1'b0;
        i_data_from_fr = 32'h11;
        step();
        for (int c = 1; c <= 6; c++) begin
            i_req_valid = c[0];
            i_req_cmd = 8'h06;
            i_req_data = 23'd7;
            if (c == 3) chk("b2b_strobe_a", o_cmd_to_fr, 32'h02800005);
            chk("b2b_busy_a", o_busy, 1);
            step();
        end
        i_req_valid = 1'b1;
        chk("b2b_rsp_a", o_rsp_valid, 1);
        chk("b2b_ready", o_req_ready, 1);
        chk("b2b_data_a", o_rsp_data, 64'h11);
        i_data_from_fr = 32'h22;
        step();
        i_req_valid = 1'b0;
        chk("b2b_setup_b", o_cmd_to_fr, 32'h06000007);
        chk("b2b_busy_b", o_busy, 1);
        repeat (6) step();
        chk("b2b_rsp_b", o_rsp_valid, 1);
        chk("b2b_data_b", o_rsp_data, 64'h22);
        step();

        // Reset during STROBE: enable drops at once and no response appears.
        i_req_valid = 1'b1;
        i_req_cmd = 8'h02;
        i_req_data = 23'd9;
        step();
        i_req_valid = 1'b0;
        repeat (2) step();
        chk("pre_rst_strobe", o_cmd_to_fr, 32'h02800009);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_word", o_cmd_to_fr, 0);
        chk("mid_rst_busy", o_busy, 0);
        step();
        i_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_rsp_valid) seen++;
            step();
        end
        chk("aborted_no_rsp", seen, 0);
        run_vec(tbl[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fr_cmd_master.md
FR_CMD_MASTER -- requirements
Module: fr_cmd_master

Interface
REQ-001 Parameter NB_C0M, default 8, command field width.
REQ-002 Parameter NB_DATA, default 24, enable bit plus payload field width.
REQ-003 Parameter NB_INST, default 32, instruction/response word width.
REQ-004 Parameter NB_BER, default 64, wide response width.
REQ-005 Parameter P_CYC, default 2, cycles per strobe phase (>=1).
REQ-006 clock  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_req_valid  in  1  request present.
REQ-009 o_req_ready  out  1  request accepted when valid&ready.
REQ-010 i_req_cmd  in  NB_C0M  command code.
REQ-011 i_req_data  in  NB_DATA-1  payload.
REQ-012 i_req_wide  in  1  64-bit read: command followed by BER_HIGH.
REQ-013 o_cmd_to_fr  out  NB_INST  instruction word {cmd, enable, payload} to file register (gpo side).
REQ-014 i_data_from_fr  in  NB_INST  data word from file register.
REQ-015 o_rsp_valid  out  1  one-cycle response strobe.
REQ-016 o_rsp_data  out  NB_BER  response data.
REQ-017 o_busy  out  1  high whenever FSM not IDLE.

Function
REQ-018 Enable bit is o_cmd_to_fr[NB_DATA-1]; cmd occupies [NB_INST-1:NB_DATA]; payload [NB_DATA-2:0].
REQ-019 FSM states: IDLE, SETUP, STROBE, HOLD, SETUP_HI, STROBE_HI, HOLD_HI.
REQ-020 o_req_ready SHALL be 1 only in IDLE; cmd/data/wide SHALL be registered on acceptance.
REQ-021 Acceptance at cycle 0 -> SETUP cycles 1..P, STROBE P+1..2P, HOLD 2P+1..3P, each lasting exactly P_CYC cycles via one phase counter.
REQ-022 SETUP and HOLD drive {cmd,0,data}; STROBE drives {cmd,1,data}.
REQ-023 i_data_from_fr SHALL be sampled on the last HOLD cycle into low word.
REQ-024 Narrow request: HOLD -> IDLE; o_rsp_data = {32'b0, low word}; o_rsp_valid high in cycle 3P+1.
REQ-025 Wide request: HOLD -> SETUP_HI; second three-phase sequence with cmd=BER_HIGH (0x0C), payload 0; high word sampled last HOLD_HI cycle; o_rsp_data = {high, low}; o_rsp_valid at cycle 6P+1.
REQ-026 o_rsp_valid SHALL assert on the cycle FSM re-enters IDLE; no backpressure; new request acceptable that same cycle (back-to-back).
REQ-027 In IDLE o_cmd_to_fr SHALL hold last word with enable bit 0.
REQ-028 i_req_valid while not ready SHALL be ignored, no state change.
REQ-029 o_rsp_data SHALL hold its value until the next response.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, o_cmd_to_fr=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, counter=0; o_req_ready=1 after release.
REQ-031 reset mid-operation SHALL drop enable immediately and produce no response for the aborted request.

Structure
REQ-032 Command codes (RESET..BER_HIGH), field widths and state encoding SHALL live in shared package fr_pkg.
REQ-033 Phase counter SHALL be sub-module fr_phase_timer (load P_CYC-1, count down, terminal pulse).

Verification
REQ-034 Reset release -> o_cmd_to_fr=0x00000000, o_req_ready=1, o_rsp_valid=0.
REQ-035 EN_TX data 1, P=2 -> o_cmd_to_fr 0x02000001 x2, 0x02800001 x2, 0x02000001 x2; o_rsp_valid at cycle 7.
REQ-036 Wide BER_E_I, model returns 0x00000003 then 0xFFFFFFFF -> second strobe shows 0x0C800000; o_rsp_data=0xFFFFFFFF00000003 at cycle 13.
REQ-037 RD_MEM addr 250, model returns 651 -> strobe word 0x068000FA; o_rsp_data=651.
REQ-038 i_req_valid held high continuously -> second request accepted exactly on first response cycle; mid-request valid toggles ignored.
REQ-039 reset asserted during STROBE -> enable bit 0 same cycle, no o_rsp_valid, next request runs normally.
